// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter register and next-PC selector for the single-cycle MIPS datapath.
// Holds PC under stall, buffers a redirect seen during a stall, and flags misaligned jr targets.
module pc_next_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_offset_sh,
   input  logic        i_jump,
   input  logic [25:0] i_jump_index,
   input  logic        i_jr,
   input  logic [31:0] i_jr_target,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4,
   output logic        o_redirect_pending,
   output logic        o_misalign_err
);

   typedef enum logic {StRun, StHold} state_t;

   state_t      r_state;
   state_t      w_state_d;
   logic [31:0] r_pc;
   logic [31:0] w_pc_d;
   logic [31:0] r_pend_target;
   logic [31:0] w_pend_target_d;
   logic        r_misalign;
   logic        w_misalign_d;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;
   logic [31:0] w_jr_tgt;
   logic [31:0] w_sel_tgt;
   logic        w_redir;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_tgt   = w_pc_plus4 + i_branch_offset_sh;
   assign w_j_tgt    = {w_pc_plus4[31:28], i_jump_index, 2'b00};
   assign w_jr_tgt   = {i_jr_target[31:2], 2'b00};
   assign w_redir    = i_jr | i_jump | i_branch_taken;

   // Priority: jr > jump > branch.
   always_comb begin
      w_sel_tgt = w_br_tgt;
      if (i_jr) begin
         w_sel_tgt = w_jr_tgt;
      end else if (i_jump) begin
         w_sel_tgt = w_j_tgt;
      end
   end

   always_comb begin
      w_state_d       = r_state;
      w_pc_d          = r_pc;
      w_pend_target_d = r_pend_target;
      case (r_state)
         StRun: begin
            if (!i_stall) begin
               w_pc_d = w_redir ? w_sel_tgt : w_pc_plus4;
            end else if (w_redir) begin
               w_pend_target_d = w_sel_tgt;
               w_state_d       = StHold;
            end
         end
         StHold: begin
            if (!i_stall) begin
               // A live redirect overrides the buffered one.
               w_pc_d    = w_redir ? w_sel_tgt : r_pend_target;
               w_state_d = StRun;
            end else if (w_redir) begin
               w_pend_target_d = w_sel_tgt;
            end
         end
         default: w_state_d = StRun;
      endcase
   end

   // A jr request is always either applied or captured on the edge, so no state qualifier needed.
   assign w_misalign_d = i_jr & (|i_jr_target[1:0]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StRun;
         r_pc          <= RESET_PC;
         r_pend_target <= 32'h0000_0000;
         r_misalign    <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_pc          <= w_pc_d;
         r_pend_target <= w_pend_target_d;
         r_misalign    <= w_misalign_d;
      end
   end

   assign o_pc               = r_pc;
   assign o_pc_plus4         = w_pc_plus4;
   assign o_redirect_pending = (r_state == StHold);
   assign o_misalign_err     = r_misalign;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed plan items plus randomized traffic
// compared every cycle against a behavioural next-PC model.
module tb_pc_next_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_offset_sh;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect_pending;
   logic        misalign_err;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   pc_next_unit #(.RESET_PC(RESET_PC)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_stall            (stall),
      .i_branch_taken     (branch_taken),
      .i_branch_offset_sh (branch_offset_sh),
      .i_jump             (jump),
      .i_jump_index       (jump_index),
      .i_jr               (jr),
      .i_jr_target        (jr_target),
      .o_pc               (pc),
      .o_pc_plus4         (pc_plus4),
      .o_redirect_pending (redirect_pending),
      .o_misalign_err     (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Behavioural model: the architectural effect of one clock edge.
   logic [31:0] m_pc;
   logic [31:0] m_pend;
   logic        m_hold;
   logic        m_mis;

   function automatic logic [31:0] target_of(input logic [31:0] cur_pc);
      logic [31:0] p4;
      p4 = cur_pc + 32'd4;
      if (jr)   return {jr_target[31:2], 2'b00};
      if (jump) return {p4[31:28], jump_index, 2'b00};
      return p4 + branch_offset_sh;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc   <= RESET_PC;
         m_pend <= 32'h0;
         m_hold <= 1'b0;
         m_mis  <= 1'b0;
      end else begin
         if (!stall) begin
            if (jr || jump || branch_taken) m_pc <= target_of(m_pc);
            else if (m_hold)                m_pc <= m_pend;
            else                            m_pc <= m_pc + 32'd4;
            m_hold <= 1'b0;
         end else if (jr || jump || branch_taken) begin
            m_pend <= target_of(m_pc);
            m_hold <= 1'b1;
         end
         m_mis <= jr && (jr_target[1:0] != 2'b00);
      end
   end

   // Compare process: mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("cmp_pc", pc, m_pc);
         check("cmp_pc_plus4", pc_plus4, m_pc + 32'd4);
         check("cmp_pending", {31'b0, redirect_pending}, {31'b0, m_hold});
         check("cmp_misalign", {31'b0, misalign_err}, {31'b0, m_mis});
      end
   end

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; branch_offset_sh = 0;
      jump = 0; jump_index = 0; jr = 0; jr_target = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Jump the PC to an aligned address via jr, then clear inputs.
   task automatic set_pc(input logic [31:0] addr);
      idle_inputs();
      jr = 1; jr_target = addr;
      cyc();
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      #12;
      check("reset_pc", pc, RESET_PC);
      check("reset_pc_plus4", pc_plus4, RESET_PC + 32'd4);
      check("reset_pending", {31'b0, redirect_pending}, 32'd0);
      check("reset_misalign", {31'b0, misalign_err}, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // 1: sequential fetch
      cyc(); check("seq_pc1", pc, 32'h4);
      cyc(); check("seq_pc2", pc, 32'h8);
      cyc(); check("seq_pc3", pc, 32'hC);
      check("seq_plus4", pc_plus4, 32'h10);
      check("seq_pending", {31'b0, redirect_pending}, 32'd0);

      // 2: backward branch and wrap-around
      set_pc(32'h0000_0100);
      branch_taken = 1; branch_offset_sh = 32'hFFFF_FFF0;
      cyc(); idle_inputs();
      check("branch_back", pc, 32'h0000_00F4);
      set_pc(32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'h0000_0000);
      branch_taken = 1; branch_offset_sh = 32'h0000_0040;
      cyc(); idle_inputs();
      check("branch_wrap", pc, 32'h0000_0040);

      // 3: priority
      set_pc(32'h4000_0010);
      jump = 1; branch_taken = 1; jump_index = 26'h0000123; branch_offset_sh = 32'h100;
      cyc(); idle_inputs();
      check("jump_over_branch", pc, 32'h4000_048C);
      set_pc(32'h4000_0010);
      jr = 1; jump = 1; branch_taken = 1; jump_index = 26'h0000123; jr_target = 32'h2000;
      cyc(); idle_inputs();
      check("jr_over_jump", pc, 32'h0000_2000);

      // 4: buffered redirect across a stall, then live redirect overriding the buffer
      set_pc(32'h0000_0100);
      stall = 1; branch_taken = 1; branch_offset_sh = 32'h0000_00FC;
      cyc(); idle_inputs(); stall = 1;
      check("stall_pc0", pc, 32'h100);
      check("stall_pend0", {31'b0, redirect_pending}, 32'd1);
      cyc(); check("stall_pc1", pc, 32'h100);
      check("stall_pend1", {31'b0, redirect_pending}, 32'd1);
      cyc(); check("stall_pc2", pc, 32'h100);
      check("stall_pend2", {31'b0, redirect_pending}, 32'd1);
      stall = 0;
      cyc();
      check("release_pc", pc, 32'h200);
      check("release_pend", {31'b0, redirect_pending}, 32'd0);
      stall = 1; branch_taken = 1; branch_offset_sh = 32'h0000_01FC;
      cyc(); idle_inputs();
      check("stall2_pend", {31'b0, redirect_pending}, 32'd1);
      jump = 1; jump_index = 26'h00000C0;
      cyc(); idle_inputs();
      check("live_beats_buf", pc, 32'h300);
      check("live_pend", {31'b0, redirect_pending}, 32'd0);

      // 5: misaligned jr
      jr = 1; jr_target = 32'h0000_1006;
      cyc(); idle_inputs();
      check("mis_pc", pc, 32'h0000_1004);
      check("mis_pulse", {31'b0, misalign_err}, 32'd1);
      cyc();
      check("mis_clear", {31'b0, misalign_err}, 32'd0);

      // 6: async reset while holding a buffered redirect
      stall = 1; jump = 1; jump_index = 26'h0000140;
      cyc(); idle_inputs(); stall = 1;
      check("hold_before_rst", {31'b0, redirect_pending}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc, RESET_PC);
      check("async_rst_pend", {31'b0, redirect_pending}, 32'd0);
      stall = 0;
      #3 rst_n = 1'b1;
      cyc(); check("post_rst_pc1", pc, RESET_PC + 32'd4);
      cyc(); check("post_rst_pc2", pc, RESET_PC + 32'd8);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         stall            = ($urandom_range(0, 2) == 0);
         branch_taken     = ($urandom_range(0, 3) == 0);
         branch_offset_sh = {{14{1'b0}}, $urandom_range(0, 32'h3FFFF)} << 2;
         if ($urandom_range(0, 1) == 1) branch_offset_sh = -branch_offset_sh;
         jump             = ($urandom_range(0, 7) == 0);
         jump_index       = 26'($urandom);
         jr               = ($urandom_range(0, 7) == 0);
         jr_target        = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            #1 rst_n = 1'b0;
            #1;
            check("rand_rst_pc", pc, RESET_PC);
            #1 rst_n = 1'b1;
         end
         cyc();
      end

      idle_inputs();
      cyc();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
